// File: rtl/score_bcd_display_pkg.sv
// Shared types and constants for the score binary-to-BCD display path.
package score_bcd_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } bcd_state_t;

  localparam int unsigned SCORE_W    = 11;
  localparam int unsigned BCD_DIGITS = 4;

endpackage

// File: rtl/score_bcd_display_if.sv
// Score-in / decimal-digits-out bundle between the score counter and the HEX drivers.
interface score_bcd_display_if
  import score_bcd_display_pkg::*;
#(
  parameter int unsigned IN_WIDTH = SCORE_W,
  parameter int unsigned DIGITS   = BCD_DIGITS
);

  logic                  frame_vs;
  logic [IN_WIDTH-1:0]   score;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     blank;
  logic                  busy;
  logic                  done;

  modport master (
    output frame_vs,
    output score,
    input  digits,
    input  blank,
    input  busy,
    input  done
  );

  modport slave (
    input  frame_vs,
    input  score,
    output digits,
    output blank,
    output busy,
    output done
  );

endinterface

// File: rtl/score_bcd_display_digit_adj.sv
// Double-dabble digit cell: a BCD nibble of 5 or more gets +3 before the shift.
module score_bcd_display_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end

endmodule

// File: rtl/score_bcd_display.sv
// Per-frame sequential binary-to-BCD converter for the score, one bit per clock,
// with a leading-zero blank mask for the HEX displays.
module score_bcd_display
  import score_bcd_display_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = SCORE_W,
  parameter int unsigned DIGITS        = BCD_DIGITS,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic               Clk,
  input  logic               Reset,
  score_bcd_display_if.slave bus
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [DIGITS-1:0] BlankRst = BLANK_LEADING ? ~(DIGITS'(1)) : '0;

  bcd_state_t            state_q, state_d;
  logic                  vs_sync1_q, vs_sync2_q, vs_prev_q;
  logic                  start;
  logic [IN_WIDTH-1:0]   bin_q, bin_d;
  logic [BcdW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BcdW-1:0]       digits_q, digits_d;
  logic [DIGITS-1:0]     blank_q, blank_d;
  logic                  done_q, done_d;
  logic [BcdW+IN_WIDTH-1:0] shifted;
  logic                  zero_above;

  // VS is asynchronous to Clk; only its synchronised rising edge starts a conversion.
  assign start = vs_sync2_q & ~vs_prev_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    score_bcd_display_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    blank_d    = blank_q;
    done_d     = 1'b0;
    zero_above = 1'b1;
    shifted    = {bcd_adj, bin_q} << 1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bin_d   = bus.score;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        {bcd_d, bin_d} = shifted;
        cnt_d          = cnt_q + CntW'(1);
        if (cnt_q == CntW'(IN_WIDTH - 1)) state_d = StDone;
      end
      StDone: begin
        digits_d = bcd_q;
        // Walk from the top digit down; a digit blanks only while everything above is zero.
        for (int i = DIGITS - 1; i >= 1; i--) begin
          zero_above = zero_above & (bcd_q[4*i +: 4] == 4'd0);
          blank_d[i] = BLANK_LEADING & zero_above;
        end
        blank_d[0] = 1'b0;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      vs_sync1_q <= 1'b0;
      vs_sync2_q <= 1'b0;
      vs_prev_q  <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      digits_q   <= '0;
      blank_q    <= BlankRst;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_sync1_q <= bus.frame_vs;
      vs_sync2_q <= vs_sync1_q;
      vs_prev_q  <= vs_sync2_q;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      blank_q    <= blank_d;
      done_q     <= done_d;
    end
  end

  assign bus.digits = digits_q;
  assign bus.blank  = blank_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Randomised and directed bench for score_bcd_display against a decimal-arithmetic model.
module tb_score_bcd_display;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  score_bcd_display_if bus ();

  score_bcd_display u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #10 Clk = ~Clk;

  int n_total = 0;
  int n_bad   = 0;

  int cyc, busy_n, first_busy, done_n, done_cyc, stable_bad;
  logic [15:0] dig_at_done;
  logic [15:0] hold_dig;
  logic [3:0]  blk_at_done;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_digits(input int s);
    logic [15:0] r;
    int p;
    p = 1;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((s / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_blank(input int s);
    logic [3:0] r;
    int p;
    p = 10;
    r = '0;
    for (int i = 1; i < 4; i++) begin
      r[i] = (s < p);
      p = p * 10;
    end
    return r;
  endfunction

  // One clock: sample away from the active edge and log busy/done activity.
  task automatic step();
    @(negedge Clk);
    cyc++;
    if (bus.busy) begin
      busy_n++;
      if (first_busy < 0) first_busy = cyc;
    end
    if (bus.done) begin
      done_n++;
      done_cyc    = cyc;
      dig_at_done = bus.digits;
      blk_at_done = bus.blank;
      hold_dig    = bus.digits;
    end else if (bus.digits !== hold_dig) begin
      stable_bad++;
    end
  endtask

  task automatic clr();
    cyc         = 0;
    busy_n      = 0;
    first_busy  = -1;
    done_n      = 0;
    done_cyc    = -1;
    stable_bad  = 0;
    dig_at_done = '0;
    blk_at_done = '0;
  endtask

  task automatic convert(input int s);
    clr();
    bus.score    = 11'(s);
    bus.frame_vs = 1'b1;
    repeat (20) step();
    bus.frame_vs = 1'b0;
    repeat (4) step();
    chk($sformatf("digits[%0d]", s), int'(dig_at_done), int'(ref_digits(s)));
    chk($sformatf("blank[%0d]", s), int'(blk_at_done), int'(ref_blank(s)));
    chk($sformatf("done_count[%0d]", s), done_n, 1);
    chk($sformatf("busy_len[%0d]", s), busy_n, 12);
    chk($sformatf("busy_first[%0d]", s), first_busy, 3);
    chk($sformatf("done_cycle[%0d]", s), done_cyc, 15);
    chk($sformatf("stable[%0d]", s), stable_bad, 0);
  endtask

  initial begin
    int s;
    bus.frame_vs = 1'b0;
    bus.score    = '0;
    hold_dig     = '0;
    clr();

    // Reset and idle
    Reset = 1'b1;
    repeat (2) step();
    Reset = 1'b0;
    clr();
    repeat (10) step();
    chk("rst_digits", int'(bus.digits), 0);
    chk("rst_blank", int'(bus.blank), 4'b1110);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", done_n, 0);

    // Directed values and boundaries
    convert(1234);
    convert(2047);
    convert(5);
    convert(90);
    convert(0);
    convert(1000);
    for (int k = 0; k < 20; k++) begin
      convert(int'($urandom_range(0, 2047)));
    end

    // Score change and second VS rise while busy
    clr();
    bus.score    = 11'd100;
    bus.frame_vs = 1'b1;
    repeat (2) step();
    bus.frame_vs = 1'b0;
    repeat (4) step();
    bus.score = 11'd777;
    step();
    bus.frame_vs = 1'b1;
    repeat (20) step();
    bus.frame_vs = 1'b0;
    repeat (4) step();
    chk("busy_ignore_done", done_n, 1);
    chk("busy_captured", int'(dig_at_done), int'(ref_digits(100)));
    convert(777);

    // Reset in the middle of a conversion
    clr();
    bus.score    = 11'd321;
    bus.frame_vs = 1'b1;
    repeat (8) step();
    Reset        = 1'b1;
    bus.frame_vs = 1'b0;
    hold_dig     = '0;
    step();
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_digits", int'(bus.digits), 0);
    chk("midrst_blank", int'(bus.blank), 4'b1110);
    Reset = 1'b0;
    done_n = 0;
    repeat (25) step();
    chk("midrst_done", done_n, 0);

    // VS held high for a long time converts once
    clr();
    s            = int'($urandom_range(0, 2047));
    bus.score    = 11'(s);
    bus.frame_vs = 1'b1;
    repeat (1000) step();
    bus.frame_vs = 1'b0;
    repeat (4) step();
    chk("vs_hold_done", done_n, 1);
    chk("vs_hold_digits", int'(dig_at_done), int'(ref_digits(s)));
    chk("vs_hold_blank", int'(blk_at_done), int'(ref_blank(s)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
